serial_adder: RTL and testbench

//   Bit-serial N-bit adder: loads two operands plus carry-in, adds LSB-first one bit per clock

---
 rtl/serial_adder_if.sv | 16 +
 rtl/serial_adder.sv | 124 ++++++++++++
 tb/tb_serial_adder.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder: start/a/b/cin in, busy/done/sum/cout out.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: LSB-first, one bit per clock, through a full adder
// made of two half_sum_gate cells plus a carry flip-flop.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_c;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic             w_p;
  logic             w_g0;
  logic             w_g1;
  logic             w_s_bit;
  logic             w_c_next;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  half_sum_gate u_ha0 (
    .i_a    (r_a_sh[0]),
    .i_b    (r_b_sh[0]),
    .o_s    (w_p),
    .o_cout (w_g0)
  );

  half_sum_gate u_ha1 (
    .i_a    (w_p),
    .i_b    (r_c),
    .o_s    (w_s_bit),
    .o_cout (w_g1)
  );

  assign w_c_next   = w_g0 | w_g1;
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  // New sum bit enters at the MSB; the concat-then-shift form also covers WIDTH=1.
  assign w_res_next = WIDTH'({w_s_bit, r_res} >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_c     <= 1'b0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_a_sh  <= bus.a;
            r_b_sh  <= bus.b;
            r_c     <= bus.cin;
            r_res   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          r_a_sh <= r_a_sh >> 1;
          r_b_sh <= r_b_sh >> 1;
          r_res  <= w_res_next;
          r_c    <= w_c_next;
          r_cnt  <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_sum   <= w_res_next;
            r_cout  <= w_c_next;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

endmodule

// Half adder cell: sum and carry of two bits.
module half_sum_gate (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_cout
);
  assign o_s    = i_a ^ i_b;
  assign o_cout = i_a & i_b;
endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8 and WIDTH=1 with a result scoreboard.
module tb_serial_adder;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  logic [8:0] exp8[$];
  logic [1:0] exp1[$];
  logic [8:0] e8;
  logic [1:0] e1;
  logic [8:0] held;

  logic [7:0] t3a [4] = '{8'h01, 8'h80, 8'hAA, 8'hF0};
  logic [7:0] t3b [4] = '{8'hFF, 8'h80, 8'h55, 8'h0F};
  logic       t3c [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  serial_adder_if #(.WIDTH(8)) if8 ();
  serial_adder_if #(.WIDTH(1)) if1 ();

  serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  serial_adder #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse pops one expected {cout,sum}.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && if8.done === 1'b1) begin
      check("sb8_pending", 32'(exp8.size() != 0), 32'd1);
      if (exp8.size() != 0) begin
        e8 = exp8.pop_front();
        check("sb8_result", 32'({if8.cout, if8.sum}), 32'(e8));
      end
    end
    if (rst_n === 1'b1 && if1.done === 1'b1) begin
      check("sb1_pending", 32'(exp1.size() != 0), 32'd1);
      if (exp1.size() != 0) begin
        e1 = exp1.pop_front();
        check("sb1_result", 32'({if1.cout, if1.sum}), 32'(e1));
      end
    end
  end

  task automatic drive8(input logic [7:0] va, input logic [7:0] vb, input logic vc);
    if8.start = 1'b1;
    if8.a     = va;
    if8.b     = vb;
    if8.cin   = vc;
    exp8.push_back(9'(va) + 9'(vb) + 9'(vc));
    @(posedge clk); #1;
    if8.start = 1'b0;
  endtask

  task automatic drive1(input logic va, input logic vb, input logic vc);
    if1.start = 1'b1;
    if1.a     = va;
    if1.b     = vb;
    if1.cin   = vc;
    exp1.push_back(2'(va) + 2'(vb) + 2'(vc));
    @(posedge clk); #1;
    if1.start = 1'b0;
  endtask

  task automatic shift_then_done8(input string tag);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check({tag, "_busy"}, 32'(if8.busy), 32'd1);
      check({tag, "_nodone"}, 32'(if8.done), 32'd0);
    end
    @(negedge clk);
    check({tag, "_done"}, 32'(if8.done), 32'd1);
    check({tag, "_idle"}, 32'(if8.busy), 32'd0);
  endtask

  task automatic wait_done8(input int max);
    int n = 0;
    do begin @(negedge clk); n++; end while (if8.done !== 1'b1 && n < max);
    check("rnd8_done_seen", 32'(if8.done), 32'd1);
  endtask

  task automatic wait_done1(input int max);
    int n = 0;
    do begin @(negedge clk); n++; end while (if1.done !== 1'b1 && n < max);
    check("rnd1_done_seen", 32'(if1.done), 32'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
    if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy8", 32'(if8.busy), 32'd0);
    check("rst_done8", 32'(if8.done), 32'd0);
    check("rst_sum8",  32'(if8.sum),  32'd0);
    check("rst_cout8", 32'(if8.cout), 32'd0);
    check("rst_busy1", 32'(if1.busy), 32'd0);
    check("rst_sum1",  32'(if1.sum),  32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic add with exact busy/done timing.
    drive8(8'h5A, 8'h3C, 1'b0);
    shift_then_done8("t1");
    check("t1_sum",  32'(if8.sum),  32'h96);
    check("t1_cout", 32'(if8.cout), 32'd0);
    @(posedge clk); #1;

    // Carry-out overflow, then a back-to-back accept in the DONE cycle.
    drive8(8'hFF, 8'h01, 1'b0);
    shift_then_done8("t2a");
    check("t2a_sum",  32'(if8.sum),  32'h00);
    check("t2a_cout", 32'(if8.cout), 32'd1);
    drive8(8'hFF, 8'h00, 1'b1);
    shift_then_done8("t2b");
    check("t2b_sum",  32'(if8.sum),  32'h00);
    check("t2b_cout", 32'(if8.cout), 32'd1);
    @(posedge clk); #1;

    // Start held high: a new operation each WIDTH+1 cycles.
    if8.start = 1'b1;
    if8.a = t3a[0]; if8.b = t3b[0]; if8.cin = t3c[0];
    exp8.push_back(9'(t3a[0]) + 9'(t3b[0]) + 9'(t3c[0]));
    @(posedge clk); #1;
    for (int j = 1; j < 4; j++) begin
      if8.a = t3a[j]; if8.b = t3b[j]; if8.cin = t3c[j];
      exp8.push_back(9'(t3a[j]) + 9'(t3b[j]) + 9'(t3c[j]));
      shift_then_done8("t3");
      @(posedge clk); #1;
    end
    if8.start = 1'b0;
    shift_then_done8("t3_last");
    held = 9'(t3a[3]) + 9'(t3b[3]) + 9'(t3c[3]);
    @(posedge clk); #1;

    // Input churn and a stray start during SHIFT are ignored; outputs hold.
    drive8(8'h0F, 8'h01, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t4_busy", 32'(if8.busy), 32'd1);
      check("t4_hold", 32'({if8.cout, if8.sum}), 32'(held));
      if (i == 2) begin
        if8.a = 8'hFF; if8.b = 8'hFF; if8.cin = 1'b1; if8.start = 1'b1;
      end
      if (i == 3) if8.start = 1'b0;
    end
    @(negedge clk);
    check("t4_done", 32'(if8.done), 32'd1);
    check("t4_sum", 32'({if8.cout, if8.sum}), 32'h011);
    @(posedge clk); #1;

    // Reset in the 4th SHIFT cycle aborts with cleared outputs and no done.
    drive8(8'h12, 8'h34, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_busy", 32'(if8.busy), 32'd1);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 32'(if8.busy), 32'd0);
    check("t5_rst_done", 32'(if8.done), 32'd0);
    check("t5_rst_sum",  32'(if8.sum),  32'd0);
    check("t5_rst_cout", 32'(if8.cout), 32'd0);
    exp8.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t5_no_done", 32'(if8.done), 32'd0);
    drive8(8'hC3, 8'h7E, 1'b1);
    shift_then_done8("t5_fresh");
    check("t5_sum", 32'({if8.cout, if8.sum}), 32'h142);
    @(posedge clk); #1;

    // WIDTH=1: one SHIFT cycle then DONE.
    drive1(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    check("w1_busy", 32'(if1.busy), 32'd1);
    @(negedge clk);
    check("w1_done", 32'(if1.done), 32'd1);
    check("w1_res", 32'({if1.cout, if1.sum}), 32'h3);
    @(posedge clk); #1;

    // Random regression, with occasional back-to-back starts.
    for (int n = 0; n < 1000; n++) begin
      drive8(8'($urandom), 8'($urandom), 1'($urandom));
      wait_done8(12);
      if ($urandom_range(0, 1) == 0) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    for (int n = 0; n < 1000; n++) begin
      drive1(1'($urandom), 1'($urandom), 1'($urandom));
      wait_done1(5);
      if ($urandom_range(0, 1) == 0) begin @(posedge clk); #1; end
    end
    repeat (3) @(negedge clk);

    check("sb8_drained", 32'(exp8.size()), 32'd0);
    check("sb1_drained", 32'(exp1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
